mp3_playback_ctrl: RTL

Track-level sequencer for the MP3 streaming path. Translates PLAY/PAUSE/STOP/LOOP commands into a sequence of single-sector SD reads (start sector + length), one 512-byte (4096-bit) sector per allocator refill. Starts the 16×256-bit data allocator only after the first sector is loaded. Decides what the allocator sees as "SD busy", so the allocator advances only on reads this block has accepted. Sits between the top-level player UI logic, the SD sector reader and the MP3 data allocator.

---
 rtl/mp3_playback_ctrl_pkg.sv | 21 ++
 rtl/mp3_sd_read_seq.sv | 98 +++++++++
 rtl/mp3_playback_ctrl.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/mp3_playback_ctrl_pkg.sv
// mp3_playback_ctrl_pkg: shared state encodings for the
// MP3 track sequencer and its SD read sub-sequencer.
package mp3_playback_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_STREAM,
    S_PAUSED,
    S_DRAIN,
    S_ERR
  } ctrl_state_e;

  typedef enum logic [1:0] {
    RD_IDLE,
    RD_REQ,
    RD_WAIT_BUSY,
    RD_WAIT_DONE
  } rd_state_e;

endpackage

// File: rtl/mp3_sd_read_seq.sv
// mp3_sd_read_seq: issues one SD sector read, waits for the
// reader busy pulse, handles timeout and bounded retries.
module mp3_sd_read_seq
  import mp3_playback_ctrl_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int TIMEOUT   = 1024,
  parameter int MAX_RETRY = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              go,
  input  logic [ADDR_W-1:0] addr,
  input  logic              abort,
  input  logic              sd_is_reading,
  output logic              req,
  output logic [ADDR_W-1:0] sector_addr,
  output logic              done,
  output logic              err,
  output logic              busy_mirror
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam int RTY_W = $clog2(MAX_RETRY + 2);

  rd_state_e        state;
  rd_state_e        state_nx;
  logic [CNT_W-1:0] wait_cnt;
  logic [RTY_W-1:0] retry_cnt;
  logic             timed_out;

  assign timed_out = (wait_cnt == CNT_W'(TIMEOUT - 1));

  // next read state; done/err are single-cycle events to the top
  always_comb begin
    state_nx = state;
    done     = 1'b0;
    err      = 1'b0;
    if (abort) begin
      state_nx = RD_IDLE;
    end else begin
      unique case (state)
        RD_IDLE: if (go) state_nx = RD_REQ;
        RD_REQ:  state_nx = RD_WAIT_BUSY;
        RD_WAIT_BUSY: begin
          if (sd_is_reading) begin
            state_nx = RD_WAIT_DONE;
          end else if (timed_out) begin
            if (retry_cnt < RTY_W'(MAX_RETRY)) begin
              state_nx = RD_REQ;
            end else begin
              state_nx = RD_IDLE;
              err      = 1'b1;
            end
          end
        end
        RD_WAIT_DONE: begin
          if (!sd_is_reading) begin
            state_nx = RD_IDLE;
            done     = 1'b1;
          end
        end
        default: state_nx = RD_IDLE;
      endcase
    end
  end

  // state, strobe, latched address, wait and retry counters
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= RD_IDLE;
      req         <= 1'b0;
      sector_addr <= '0;
      wait_cnt    <= '0;
      retry_cnt   <= '0;
      busy_mirror <= 1'b0;
    end else begin
      state <= state_nx;
      req   <= (state_nx == RD_REQ);
      busy_mirror <= sd_is_reading && !abort &&
                     (state == RD_WAIT_BUSY ||
                      state == RD_WAIT_DONE);
      if (state_nx == RD_REQ) begin
        if (state == RD_IDLE) begin
          sector_addr <= addr;
          retry_cnt   <= '0;
        end else begin
          retry_cnt <= retry_cnt + RTY_W'(1);
        end
      end
      if (state == RD_REQ)
        wait_cnt <= '0;
      else if (state == RD_WAIT_BUSY)
        wait_cnt <= wait_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/mp3_playback_ctrl.sv
// mp3_playback_ctrl: track-level sequencer turning player
// commands into per-sector SD reads for the MP3 allocator.
module mp3_playback_ctrl
  import mp3_playback_ctrl_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int LEN_W     = 16,
  parameter int TIMEOUT   = 1024,
  parameter int MAX_RETRY = 3
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              PLAY,
  input  logic              STOP,
  input  logic              PAUSE,
  input  logic              LOOP,
  input  logic [ADDR_W-1:0] TRACK_START,
  input  logic [LEN_W-1:0]  TRACK_LEN,
  input  logic              SD_IS_READING,
  input  logic              NEED_NEW_DATA,
  output logic              SD_READ_REQ,
  output logic [ADDR_W-1:0] SD_SECTOR_ADDR,
  output logic              ALLOC_START,
  output logic              ALLOC_SD_BUSY,
  output logic              PLAYING,
  output logic              TRACK_DONE,
  output logic              ERROR,
  output logic [LEN_W-1:0]  SECTOR_IDX
);

  ctrl_state_e       state;
  ctrl_state_e       state_nx;
  logic [ADDR_W-1:0] start_q;
  logic [ADDR_W-1:0] start_nx;
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  len_nx;
  logic [LEN_W-1:0]  idx_nx;
  logic              nnd_q;
  logic              nnd_q2;
  logic              nnd_rise;
  logic              go;
  logic              abort;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_done;
  logic              rd_err;
  logic              playing_nx;
  logic              done_nx;
  logic              error_nx;
  logic              alloc_nx;

  assign nnd_rise = nnd_q && !nnd_q2;

  // track policy: play, stop, pause, loop and end of track
  always_comb begin
    state_nx   = state;
    start_nx   = start_q;
    len_nx     = len_q;
    idx_nx     = SECTOR_IDX;
    playing_nx = PLAYING;
    done_nx    = 1'b0;
    error_nx   = ERROR;
    alloc_nx   = ALLOC_START;
    go         = 1'b0;
    abort      = 1'b0;
    rd_addr    = start_q + ADDR_W'(SECTOR_IDX);
    if (STOP && state != S_IDLE) begin
      abort      = (state == S_READ);
      state_nx   = (state == S_READ || state == S_DRAIN) ?
                   S_DRAIN : S_IDLE;
      playing_nx = 1'b0;
      alloc_nx   = 1'b0;
    end else begin
      unique case (state)
        S_IDLE, S_ERR: begin
          if (PLAY) begin
            error_nx = 1'b0;
            start_nx = TRACK_START;
            len_nx   = TRACK_LEN;
            idx_nx   = '0;
            if (TRACK_LEN == '0) begin
              done_nx  = 1'b1;
              state_nx = S_IDLE;
            end else begin
              playing_nx = 1'b1;
              go         = 1'b1;
              rd_addr    = TRACK_START;
              state_nx   = S_READ;
            end
          end
        end
        S_READ: begin
          if (rd_done) begin
            idx_nx   = SECTOR_IDX + LEN_W'(1);
            alloc_nx = 1'b1;
            state_nx = S_STREAM;
          end else if (rd_err) begin
            error_nx   = 1'b1;
            playing_nx = 1'b0;
            state_nx   = S_ERR;
          end
        end
        S_STREAM: begin
          if (nnd_rise) begin
            if (SECTOR_IDX < len_q) begin
              if (PAUSE) begin
                state_nx = S_PAUSED;
              end else begin
                go       = 1'b1;
                state_nx = S_READ;
              end
            end else if (LOOP) begin
              idx_nx   = '0;
              go       = 1'b1;
              rd_addr  = start_q;
              state_nx = S_READ;
            end else begin
              done_nx    = 1'b1;
              playing_nx = 1'b0;
              state_nx   = S_IDLE;
            end
          end
        end
        S_PAUSED: begin
          if (!PAUSE) begin
            go       = 1'b1;
            state_nx = S_READ;
          end
        end
        S_DRAIN: if (!SD_IS_READING) state_nx = S_IDLE;
        default: state_nx = S_IDLE;
      endcase
    end
  end

  // registered track state and outputs
  always_ff @(posedge CLK) begin
    if (RST) begin
      state       <= S_IDLE;
      start_q     <= '0;
      len_q       <= '0;
      SECTOR_IDX  <= '0;
      nnd_q       <= 1'b0;
      nnd_q2      <= 1'b0;
      PLAYING     <= 1'b0;
      TRACK_DONE  <= 1'b0;
      ERROR       <= 1'b0;
      ALLOC_START <= 1'b0;
    end else begin
      state       <= state_nx;
      start_q     <= start_nx;
      len_q       <= len_nx;
      SECTOR_IDX  <= idx_nx;
      nnd_q       <= NEED_NEW_DATA;
      nnd_q2      <= nnd_q;
      PLAYING     <= playing_nx;
      TRACK_DONE  <= done_nx;
      ERROR       <= error_nx;
      ALLOC_START <= alloc_nx;
    end
  end

  mp3_sd_read_seq #(
    .ADDR_W    (ADDR_W),
    .TIMEOUT   (TIMEOUT),
    .MAX_RETRY (MAX_RETRY)
  ) u_rd (
    .clk           (CLK),
    .rst           (RST),
    .go            (go),
    .addr          (rd_addr),
    .abort         (abort),
    .sd_is_reading (SD_IS_READING),
    .req           (SD_READ_REQ),
    .sector_addr   (SD_SECTOR_ADDR),
    .done          (rd_done),
    .err           (rd_err),
    .busy_mirror   (ALLOC_SD_BUSY)
  );

endmodule
